seg_scan_4digit: RTL
====================

# seg_scan_4digit

Four-digit multiplexed seven-segment display driver. It consumes the 500 Hz square wave from the clock divider as a scan-rate strobe and steps through four digits, one per strobe period. Each digit's anode stays off for a short blanking window before it is lit, which suppresses ghosting. Sits between the divider and the board's common-anode display pins.

## Interface
- BLANK_CYCLES, default 16, number of `clock_in` cycles all anodes are held off before each digit is lit; legal range 1..255.
- clock_in  input  1  system clock (100 MHz on the board).
- reset_n  input  1  synchronous, active-low reset, sampled on rising `clock_in`.
- clock_500  input  1  divider output. It is registered in the `clock_in` domain; only its rising edge is used.
- digits  input  16  four hex nibbles. `digits[3:0]` is digit 0 (rightmost) and `digits[15:12]` is digit 3 (leftmost).
- dp_in  input  4  decimal-point request per digit, active-high.
- blank_in  input  4  force the digit dark, active-high.
- an  output  4  anode enables, active-low, one-hot-low when lit.
- seg  output  7  segments `{g,f,e,d,c,b,a}`, active-low.
- dp  output  1  decimal point, active-low.
- scan_idx  output  2  index of the digit currently selected.

## Operation
- **Tick detect:** `clock_500_q` registers `clock_500`. `tick = clock_500 & ~clock_500_q`, one `clock_in` cycle per 500 Hz period.
- **FSM states:**
  - IDLE: after reset, waiting for the first tick.
  - BLANK: anodes off, blank counter running.
  - ON: selected digit lit.
- **Transitions:**
  - Any state to BLANK on `tick`. At that point `scan_idx` advances with wrap (3 to 0), the counter is loaded with BLANK_CYCLES, and `an`/`seg`/`dp` go to all-ones.
  - BLANK to ON when the counter reaches 0 (one decrement per cycle).
  - ON holds until the next tick.
- **Frame latch:** when `scan_idx` advances to 0, `digits`, `dp_in` and `blank_in` are captured into shadow registers. All four digits of a frame show coherent data. Input changes take effect at the next frame.
- **Decode (hex, active-low `{g..a}`):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- **Lit outputs in ON:**
  - `an = ~(4'b0001 << scan_idx)`.
  - `seg` = decode of the shadow nibble.
  - `dp = ~shadow_dp[scan_idx]`.
  - If shadow blank is set for the digit, `seg` = 1111111 and `dp` = 1, while `an` stays asserted.
- **Tick during BLANK:** restarts BLANK for the next index. The counter is reloaded and no digit is lit.
- **Reset (reset_n=0 at an edge):** all registers return to reset values on the next edge, even mid-scan. The shadow registers clear to 0.

## Timing
- **Reset values:**
  - `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1.
  - `scan_idx` = 3, so the first tick selects digit 0 and latches the frame.
  - State IDLE, `clock_500_q` = 0.
- **Tick timing:** `clock_500` first samples high at edge T.
  - From the output at T+1 to the output at T+BLANK_CYCLES: `an` = 1111.
  - From edge T+1+BLANK_CYCLES: `an` is low for the selected digit.
- **Scan rate:** 4 digits per 4 ticks, giving a 125 Hz frame rate with a 500 Hz divider.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **LEADING_ZERO_BLANK_EN defined:** digit k (k = 3..1) is forced dark when its shadow nibble and every higher shadow nibble are 0. Digit 0 is never suppressed. The digit's `dp` still follows `dp_in`.
- **LEADING_ZERO_BLANK_EN undefined:** every digit is displayed as decoded, including leading zeros.

## Test plan
- **Reset:** hold `reset_n`=0 for 5 cycles with `clock_500` toggling, then release. Required: `an`=1111, `seg`=1111111, `dp`=1, `scan_idx`=3 until the first rising edge of `clock_500`.
- **Basic scan:** `digits`=16'h1234, BLANK_CYCLES=16, tick at T.
  - `an`=1111 for T+1..T+16.
  - From T+17: `an`=1110 and `seg`=0011001 ('4').
  - Next three ticks show 3, 2, 1 on `an`=1101, 1011, 0111.
- **Frame coherence:** change `digits` from 16'h1234 to 16'hABCD while `scan_idx`=1. Required: digits 2 and 3 still show 2 and 1; the next frame shows D, C, b, A.
- **DP and forced blank:** `dp_in`=4'b0100, `blank_in`=4'b0001. Required:
  - Digit 0: `an`=1110 with `seg`=1111111.
  - Digit 2: `dp`=0.
  - All other digits: `dp`=1.
- **Leading-zero blanking:** `digits`=16'h0050.
  - With LEADING_ZERO_BLANK_EN: digits 3 and 2 have `seg`=1111111, digit 1 shows '5', digit 0 shows '0'.
  - Without the macro: digits 3 and 2 show 1000000.
- **Mid-operation reset and back-to-back ticks:**
  - Assert `reset_n`=0 during ON for digit 2. Required: reset values on the next edge.
  - Force two ticks 5 cycles apart with BLANK_CYCLES=16. Required: no digit is lit between them, and `scan_idx` advances twice.

Source files
------------

// File: rtl/seg_scan_4digit.sv
// Four-digit multiplexed common-anode seven-segment scanner with a blanking window before each digit.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is never suppressed).
module seg_scan_4digit #(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        clock_500,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  scan_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  scan_idx_q, scan_idx_d;
  logic        clock_500_q, clock_500_d;
  logic [15:0] shadow_digits_q, shadow_digits_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_blank_q, shadow_blank_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        tick;
  logic [3:0]  nibble;
  logic        lz_dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick   = clock_500 & ~clock_500_q;
  assign nibble = shadow_digits_q[{scan_idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_dark = 1'b0;
    case (scan_idx_q)
      2'd3:    lz_dark = (shadow_digits_q[15:12] == 4'h0);
      2'd2:    lz_dark = (shadow_digits_q[15:8] == 8'h00);
      2'd1:    lz_dark = (shadow_digits_q[15:4] == 12'h000);
      default: lz_dark = 1'b0;
    endcase
  end
`else
  assign lz_dark = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    scan_idx_d      = scan_idx_q;
    clock_500_d     = clock_500;
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_blank_d  = shadow_blank_q;

    case (state_q)
      BLANK: begin
        if (cnt_q == 8'd0) state_d = ON;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: ;
    endcase

    // A tick always wins: restart blanking for the next digit, latching a new frame at digit 0.
    if (tick) begin
      state_d    = BLANK;
      cnt_d      = 8'(BLANK_CYCLES);
      scan_idx_d = scan_idx_q + 2'd1;
      if (scan_idx_d == 2'd0) begin
        shadow_digits_d = digits;
        shadow_dp_d     = dp_in;
        shadow_blank_d  = blank_in;
      end
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_d == ON) begin
      an_d  = ~(4'b0001 << scan_idx_q);
      seg_d = (shadow_blank_q[scan_idx_q] || lz_dark) ? 7'b1111111 : hex_to_seg(nibble);
      dp_d  = shadow_blank_q[scan_idx_q] ? 1'b1 : ~shadow_dp_q[scan_idx_q];
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      scan_idx_q      <= 2'd3;
      clock_500_q     <= 1'b0;
      shadow_digits_q <= 16'h0000;
      shadow_dp_q     <= 4'h0;
      shadow_blank_q  <= 4'h0;
      an_q            <= 4'b1111;
      seg_q           <= 7'b1111111;
      dp_q            <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      scan_idx_q      <= scan_idx_d;
      clock_500_q     <= clock_500_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_blank_q  <= shadow_blank_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign scan_idx = scan_idx_q;

endmodule
